// File: rtl/morse_tx_scheduler.sv
// Morse keyer: queues {sym_len, sym_bits} symbols in a circular FIFO and keys dit/dah marks on unit timing.
// Build option MORSE_WORD_GAP_EN: len==0 entries are queued and emit a 4-unit word gap (else they are dropped).
//   state    | meaning
//   IDLE     | waiting for a queued entry
//   MARK     | keyed element (1 unit dit, 3 units dah)
//   GAP      | 1-unit space after every element
//   CHAR_GAP | 2 further units closing a character
//   WORD_GAP | 4 units for a word-gap entry (MORSE_WORD_GAP_EN only)
module morse_tx_scheduler #(
  parameter int BUFFER_LENGTH = 10,
  parameter int UNIT_CYCLES   = 2400000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sym_bits,
  input  logic [2:0] sym_len,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       morse_code_out,
  output logic       dit_out,
  output logic       dah_out,
  output logic       busy
);

  localparam int PTR_W = (BUFFER_LENGTH > 1) ? $clog2(BUFFER_LENGTH) : 1;
  localparam int CNT_W = $clog2(BUFFER_LENGTH + 1);
  localparam int TMR_W = $clog2(4 * UNIT_CYCLES);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUFFER_LENGTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_LENGTH);

  // Timer load values are duration-1: the down-counter terminates at zero.
  localparam logic [TMR_W-1:0] T_DIT  = TMR_W'(UNIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] T_CHAR = TMR_W'(2 * UNIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] T_DAH  = TMR_W'(3 * UNIT_CYCLES - 1);
`ifdef MORSE_WORD_GAP_EN
  localparam logic [TMR_W-1:0] T_WORD = TMR_W'(4 * UNIT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MARK     = 3'd1,
    GAP      = 3'd2,
    CHAR_GAP = 3'd3
`ifdef MORSE_WORD_GAP_EN
    , WORD_GAP = 3'd4
`endif
  } state_t;

  logic [7:0]       mem_q [BUFFER_LENGTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  state_t           state_q, state_d;
  logic [2:0]       elem_q, elem_d;
  logic [2:0]       len_q, len_d;
  logic [4:0]       bits_q, bits_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             dit_q, dit_d;
  logic             dah_q, dah_d;

  logic       fifo_empty;
  logic       fifo_full;
  logic       push_en;
  logic       pop_en;
  logic       load_next;
  logic       store_ok;
  logic [2:0] wr_len;
  logic [7:0] head;
  logic [2:0] head_len;
  logic [4:0] head_bits;
  logic [2:0] elem_nx;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign sym_ready  = !fifo_full;

`ifdef MORSE_WORD_GAP_EN
  assign store_ok = 1'b1;
`else
  // Word-gap entries still complete the handshake but are never stored.
  assign store_ok = (sym_len != 3'd0);
`endif

  assign push_en   = sym_valid && sym_ready && store_ok;
  assign wr_len    = (sym_len > 3'd5) ? 3'd5 : sym_len;
  assign head      = mem_q[rd_ptr_q];
  assign head_len  = head[7:5];
  assign head_bits = head[4:0];
  assign elem_nx   = elem_q + 3'd1;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    if (push_en && !pop_en)      count_d = count_q + 1'b1;
    else if (!push_en && pop_en) count_d = count_q - 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    len_d     = len_q;
    bits_d    = bits_q;
    tmr_d     = tmr_q;
    pop_en    = 1'b0;
    load_next = 1'b0;
    dit_d     = 1'b0;
    dah_d     = 1'b0;

    case (state_q)
      IDLE: load_next = !fifo_empty;
      MARK: begin
        if (tmr_q == '0) begin
          state_d = GAP;
          tmr_d   = T_DIT;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      GAP: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else if (elem_nx == len_q) begin
          state_d = CHAR_GAP;
          tmr_d   = T_CHAR;
        end else begin
          state_d = MARK;
          elem_d  = elem_nx;
          tmr_d   = bits_q[elem_nx] ? T_DAH : T_DIT;
        end
      end
      // Terminal gap cycles chain straight into the next entry so silence is exact.
      CHAR_GAP: begin
        if (tmr_q == '0) begin
          state_d   = IDLE;
          load_next = !fifo_empty;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
`ifdef MORSE_WORD_GAP_EN
      WORD_GAP: begin
        if (tmr_q == '0) begin
          state_d   = IDLE;
          load_next = !fifo_empty;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (load_next) begin
      pop_en = 1'b1;
      elem_d = '0;
      len_d  = head_len;
      bits_d = head_bits;
`ifdef MORSE_WORD_GAP_EN
      if (head_len == 3'd0) begin
        state_d = WORD_GAP;
        tmr_d   = T_WORD;
      end else
`endif
      begin
        state_d = MARK;
        tmr_d   = head_bits[0] ? T_DAH : T_DIT;
      end
    end

    dit_d = (state_d == MARK) && !bits_d[elem_d];
    dah_d = (state_d == MARK) &&  bits_d[elem_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      elem_q   <= '0;
      len_q    <= '0;
      bits_q   <= '0;
      tmr_q    <= '0;
      dit_q    <= 1'b0;
      dah_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      elem_q   <= elem_d;
      len_q    <= len_d;
      bits_q   <= bits_d;
      tmr_q    <= tmr_d;
      dit_q    <= dit_d;
      dah_q    <= dah_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= {wr_len, sym_bits};
  end

  assign dit_out        = dit_q;
  assign dah_out        = dah_q;
  assign morse_code_out = dit_q | dah_q;
  assign busy           = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_morse_tx_scheduler.sv
// Scoreboard bench for morse_tx_scheduler (UNIT_CYCLES=4, BUFFER_LENGTH=4); expected marks queued at push time.
module tb_morse_tx_scheduler;
  localparam int UNIT  = 4;
  localparam int DEPTH = 4;
`ifdef MORSE_WORD_GAP_EN
  localparam int WORD_SILENCE = 7 * UNIT;
`else
  localparam int WORD_SILENCE = 3 * UNIT;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] sym_bits = '0;
  logic [2:0] sym_len = '0;
  logic       sym_valid = 1'b0;
  logic       sym_ready, morse_code_out, dit_out, dah_out, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit is_dah;
    int len;
    int gap;
  } mark_t;
  mark_t sb[$];

  int run_len = 0, run_start = 0, last_start = 0, last_end = 0, marks = 0;
  bit run_dah = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  morse_tx_scheduler #(.BUFFER_LENGTH(DEPTH), .UNIT_CYCLES(UNIT)) dut (
    .clk(clk), .rst(rst), .sym_bits(sym_bits), .sym_len(sym_len), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .morse_code_out(morse_code_out), .dit_out(dit_out),
    .dah_out(dah_out), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Mark monitor: measures each keyed run and compares it with the scoreboard head.
  always @(negedge clk) begin : mon
    mark_t m;
    if (rst) begin
      run_len = 0;
    end else begin
      check_eq("dit_dah_exclusive", dit_out & dah_out, 0);
      check_eq("morse_is_or", morse_code_out, dit_out | dah_out);
      if (morse_code_out) begin
        if (run_len == 0) begin
          run_start = cyc;
          run_dah   = dah_out;
        end else begin
          check_eq("mark_type_stable", dah_out, run_dah);
        end
        run_len++;
      end else if (run_len > 0) begin
        marks++;
        if (sb.size() == 0) begin
          check_eq("unexpected_mark", 1, 0);
        end else begin
          m = sb.pop_front();
          check_eq("mark_kind", run_dah, m.is_dah);
          check_eq("mark_len", run_len, m.len);
          if (m.gap >= 0) check_eq("silence_before_mark", run_start - last_end, m.gap);
        end
        last_start = run_start;
        last_end   = cyc;
        run_len    = 0;
      end
    end
  end

  // Drives one entry (holding it while sym_ready is low) and queues its expected marks.
  task automatic push(input logic [4:0] bits, input logic [2:0] len, input int gap0, output int pcyc);
    int n;
    bit rdy;
    n = (len > 3'd5) ? 5 : int'(len);
    sym_bits  = bits;
    sym_len   = len;
    sym_valid = 1'b1;
    pcyc      = -1;
    for (int i = 0; i < 400; i++) begin
      rdy = sym_ready;
      if (rdy) pcyc = cyc;
      @(posedge clk); #2;
      if (rdy) break;
    end
    sym_valid = 1'b0;
    if (pcyc < 0) begin
      check_eq("push_accept_timeout", 0, 1);
    end else begin
      for (int k = 0; k < n; k++)
        sb.push_back('{is_dah: bits[k], len: (bits[k] ? 3 * UNIT : UNIT), gap: (k == 0 ? gap0 : UNIT)});
    end
  endtask

  task automatic wait_idle(output int icyc);
    icyc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (!busy) begin
        icyc = cyc;
        break;
      end
    end
    if (icyc < 0) check_eq("idle_timeout", 0, 1);
    check_eq("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int pc, pf, ic, m0;
    bit seen;
    logic [4:0] rb;
    logic [2:0] rl;

    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_morse", morse_code_out, 0);
    check_eq("rst_dit", dit_out, 0);
    check_eq("rst_dah", dah_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", sym_ready, 1);
    rst = 1'b0;
    @(posedge clk); #2;

    // 'E': one dit two cycles after the push, then 12 silent cycles before idle
    push(5'b00000, 3'd1, -1, pc);
    wait_idle(ic);
    check_eq("e_mark_latency", last_start - pc, 2);
    check_eq("e_tail_silence", ic - last_end, 3 * UNIT);

    // dit dah dit
    push(5'b00010, 3'd3, -1, pc);
    wait_idle(ic);
    check_eq("r_tail_silence", ic - last_end, 3 * UNIT);

    // len 7 clamps to 5 dahs
    m0 = marks;
    push(5'b11111, 3'd7, -1, pc);
    wait_idle(ic);
    check_eq("clamp_mark_count", marks - m0, 5);

    // Fill the FIFO behind a long character; fifth entry waits for the first pop
    push(5'b11111, 3'd5, -1, pc);
    push(5'b00010, 3'd2, 3 * UNIT, pc);
    push(5'b00001, 3'd2, 3 * UNIT, pc);
    push(5'b00000, 3'd3, 3 * UNIT, pc);
    push(5'b00111, 3'd3, 3 * UNIT, pc);
    check_eq("full_ready_low", sym_ready, 0);
    check_eq("full_busy", busy, 1);
    push(5'b00101, 3'd3, 3 * UNIT, pf);
    check_eq("fifth_accept_cycle", pf, run_start);
    check_eq("fifth_during_mark", morse_code_out, 1);
    wait_idle(ic);

    // 'E', word gap, 'E'
    m0 = marks;
    push(5'b00000, 3'd1, -1, pc);
    push(5'b00000, 3'd0, -1, pc);
    check_eq("word_entry_accepted", pc >= 0, 1);
    push(5'b00000, 3'd1, WORD_SILENCE, pc);
    wait_idle(ic);
    check_eq("word_mark_count", marks - m0, 2);

    // Reset during a dah with two entries queued
    push(5'b00011, 3'd2, -1, pc);
    push(5'b00000, 3'd1, 3 * UNIT, pc);
    push(5'b00001, 3'd1, 3 * UNIT, pc);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (dah_out) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("dah_seen_before_rst", seen, 1);
    rst = 1'b1;
    sb.delete();
    m0 = marks;
    @(posedge clk); #2;
    check_eq("abort_morse", morse_code_out, 0);
    check_eq("abort_dit", dit_out, 0);
    check_eq("abort_dah", dah_out, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ready", sym_ready, 1);
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #2;
    check_eq("abort_no_marks", marks - m0, 0);
    check_eq("abort_still_idle", busy, 0);

    // Random characters, one at a time
    for (int r = 0; r < 6; r++) begin
      rb = 5'($urandom_range(0, 31));
      rl = 3'($urandom_range(1, 7));
      push(rb, rl, -1, pc);
      wait_idle(ic);
      check_eq("rand_latency", last_start >= pc + 2, 1);
      check_eq("rand_tail_silence", ic - last_end, 3 * UNIT);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
